// File: rtl/refresh_sequencer.sv
// DRAM refresh command sequencer: acquires the command bus, optionally precharges all banks,
// then issues REF_COUNT refresh commands with tRP/tRFC spacing and acknowledges completion.
module refresh_sequencer #(
    parameter int T_RP      = 2,
    parameter int T_RFC     = 26,
    parameter int REF_COUNT = 8,
    parameter int TIMER_W   = 8,
    parameter int CNT_W     = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       refresh_i,
    input  logic       bus_grant_i,
    input  logic       banks_open_i,
    output logic       bus_req_o,
    output logic       cmd_valid_o,
    output logic [1:0] cmd_code_o,
    output logic       refreshed_o,
    output logic       busy_o
);

    // state    | meaning
    // IDLE     | waiting for a refresh request
    // REQ      | requesting the command bus; refresh withdrawal aborts
    // PRE      | PRECHARGE-ALL strobe
    // WAIT_RP  | tRP spacing before the first REF
    // REF      | REF strobe
    // WAIT_RFC | tRFC spacing after a REF
    // DONE     | one-cycle completion acknowledge
    typedef enum logic [2:0] {
        IDLE, REQ, PRE, WAIT_RP, REF, WAIT_RFC, DONE
    } state_t;

    localparam logic [1:0]         CMD_NOP  = 2'b00;
    localparam logic [1:0]         CMD_PREA = 2'b01;
    localparam logic [1:0]         CMD_REF  = 2'b10;
    localparam logic [TIMER_W-1:0] RP_LOAD  = TIMER_W'(T_RP - 2);
    localparam logic [TIMER_W-1:0] RFC_LOAD = TIMER_W'(T_RFC - 2);
    localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(REF_COUNT);

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0]   ref_cnt_q, ref_cnt_d;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            ref_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            ref_cnt_q <= ref_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        ref_cnt_d = ref_cnt_q;
        case (state_q)
            IDLE: begin
                if (refresh_i) state_d = REQ;
            end
            REQ: begin
                if (!refresh_i) begin
                    state_d = IDLE;
                end else if (bus_grant_i) begin
                    ref_cnt_d = '0;
                    state_d   = banks_open_i ? PRE : REF;
                end
            end
            PRE: begin
                timer_d = RP_LOAD;
                state_d = WAIT_RP;
            end
            WAIT_RP: begin
                if (timer_q == '0) state_d = REF;
                else               timer_d = timer_q - 1'b1;
            end
            REF: begin
                ref_cnt_d = ref_cnt_q + 1'b1;
                timer_d   = RFC_LOAD;
                state_d   = WAIT_RFC;
            end
            WAIT_RFC: begin
                if (timer_q == '0) state_d = (ref_cnt_q == CNT_MAX) ? DONE : REF;
                else               timer_d = timer_q - 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the state register only
    always_comb begin
        bus_req_o   = 1'b0;
        cmd_valid_o = 1'b0;
        cmd_code_o  = CMD_NOP;
        refreshed_o = 1'b0;
        busy_o      = (state_q != IDLE);
        case (state_q)
            REQ, WAIT_RP, WAIT_RFC: bus_req_o = 1'b1;
            PRE: begin
                bus_req_o   = 1'b1;
                cmd_valid_o = 1'b1;
                cmd_code_o  = CMD_PREA;
            end
            REF: begin
                bus_req_o   = 1'b1;
                cmd_valid_o = 1'b1;
                cmd_code_o  = CMD_REF;
            end
            DONE:    refreshed_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_refresh_sequencer.sv
// Scoreboard bench: a small-timing instance checked cycle by cycle against an expected output
// trace, plus a default-parameter instance driven by a behavioural refresh tracker.
module tb_refresh_sequencer;

    localparam int TRP = 2;
    localparam int TRFC = 4;
    localparam int NREF = 2;

    // {bus_req, cmd_valid, cmd_code, refreshed, busy}
    localparam logic [5:0] V_IDLE = 6'b000000;
    localparam logic [5:0] V_BUS  = 6'b100001;
    localparam logic [5:0] V_PRE  = 6'b110101;
    localparam logic [5:0] V_REF  = 6'b111001;
    localparam logic [5:0] V_DONE = 6'b000011;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic refresh = 1'b0, grant = 1'b0, banks_open = 1'b0;
    logic bus_req, cmd_valid, refreshed, busy;
    logic [1:0] cmd_code;

    logic d_refresh, d_bus_req, d_cmd_valid, d_refreshed, d_busy;
    logic [1:0] d_cmd_code;
    logic trk_en = 1'b0;
    int unsigned trk_cnt = 0;
    localparam int unsigned TRK_THR = 1000;

    int nvec = 0;
    int nerr = 0;
    logic [5:0] exp_q[$];

    always #5 clk = ~clk;

    refresh_sequencer #(.T_RP(TRP), .T_RFC(TRFC), .REF_COUNT(NREF), .TIMER_W(8), .CNT_W(4)) u_dut (
        .clk_i(clk), .reset_i(reset_n), .refresh_i(refresh), .bus_grant_i(grant),
        .banks_open_i(banks_open), .bus_req_o(bus_req), .cmd_valid_o(cmd_valid),
        .cmd_code_o(cmd_code), .refreshed_o(refreshed), .busy_o(busy)
    );

    refresh_sequencer u_dflt (
        .clk_i(clk), .reset_i(reset_n), .refresh_i(d_refresh), .bus_grant_i(1'b1),
        .banks_open_i(1'b1), .bus_req_o(d_bus_req), .cmd_valid_o(d_cmd_valid),
        .cmd_code_o(d_cmd_code), .refreshed_o(d_refreshed), .busy_o(d_busy)
    );

    // Behavioural tracker: raises refresh at the threshold, clears it on the acknowledge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_refresh <= 1'b0;
        end else if (d_refreshed) begin
            d_refresh <= 1'b0;
        end else if (trk_en && trk_cnt == TRK_THR) begin
            d_refresh <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (trk_en) trk_cnt <= (trk_cnt == TRK_THR) ? 0 : trk_cnt + 1;
    end

    function automatic logic [5:0] outs();
        return {bus_req, cmd_valid, cmd_code, refreshed, busy};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // g: REQ cycles with grant low before grant arrives; a>0: refresh withdrawn after a REQ cycles
    task automatic run_seq(input logic bo, input int g, input int a, input string tag);
        int n;
        logic [5:0] e;
        exp_q.delete();
        if (a > 0) begin
            repeat (a) exp_q.push_back(V_BUS);
            repeat (3) exp_q.push_back(V_IDLE);
        end else begin
            repeat (g + 1) exp_q.push_back(V_BUS);
            if (bo) begin
                exp_q.push_back(V_PRE);
                repeat (TRP - 1) exp_q.push_back(V_BUS);
            end
            repeat (NREF) begin
                exp_q.push_back(V_REF);
                repeat (TRFC - 1) exp_q.push_back(V_BUS);
            end
            exp_q.push_back(V_DONE);
            repeat (2) exp_q.push_back(V_IDLE);
        end
        n = exp_q.size();
        refresh = 1'b1;
        banks_open = bo;
        grant = (a == 0) && (g == 0);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check_val($sformatf("%s_c%0d", tag, k), 32'(outs()), 32'(e));
            if (a > 0) begin
                if (k == a) refresh = 1'b0;
            end else begin
                grant = (k >= g + 1);
            end
            if (refreshed) refresh = 1'b0;
        end
        grant = 1'b0;
        refresh = 1'b0;
    endtask

    task automatic run_dflt();
        int c, last, npre, nref, npulse, after;
        logic last_pre, finished;
        c = 0; last = 0; npre = 0; nref = 0; npulse = 0; after = 0;
        last_pre = 1'b0; finished = 1'b0;
        @(negedge clk);
        trk_cnt = TRK_THR - 3;
        trk_en = 1'b1;
        while (c < 600 && !(finished && after >= 60)) begin
            @(negedge clk);
            c++;
            if (finished) after++;
            if (d_cmd_valid && d_cmd_code == 2'b01) begin
                npre++;
                last = c;
                last_pre = 1'b1;
            end else if (d_cmd_valid && d_cmd_code == 2'b10) begin
                if (nref == 0)
                    check_val("dflt_pre_ref_gap", 32'(c - last), 32'd2);
                else
                    check_val($sformatf("dflt_ref_gap%0d", nref), 32'(c - last), 32'd26);
                nref++;
                last = c;
                last_pre = 1'b0;
            end
            if (d_refreshed) begin
                npulse++;
                check_val("dflt_end_gap", 32'(c - last), 32'd26);
                finished = 1'b1;
            end
            if (finished && after == 1) check_val("dflt_trk_cleared", 32'(d_refresh), 32'd0);
        end
        check_val("dflt_completed", 32'(finished), 32'd1);
        check_val("dflt_npre", 32'(npre), 32'd1);
        check_val("dflt_nref", 32'(nref), 32'd8);
        check_val("dflt_npulse", 32'(npulse), 32'd1);
        check_val("dflt_no_retrig", 32'({d_bus_req, d_busy}), 32'd0);
        check_val("dflt_last_ref", 32'(last_pre), 32'd0);
        trk_en = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_val("rst_outs", 32'(outs()), 32'(V_IDLE));
        check_val("rst_dflt", 32'({d_bus_req, d_cmd_valid, d_cmd_code, d_refreshed, d_busy}), 32'd0);
        reset_n = 1'b1;

        run_seq(1'b1, 0, 0, "open");
        run_seq(1'b0, 0, 0, "closed");
        run_seq(1'b1, 5, 0, "lategrant");
        run_seq(1'b0, 3, 0, "lategrant_closed");
        run_seq(1'b1, 0, 3, "abort");

        // reset in the middle of WAIT_RFC
        refresh = 1'b1; banks_open = 1'b0; grant = 1'b1;
        repeat (4) @(negedge clk);
        check_val("pre_rst_state", 32'(outs()), 32'(V_BUS));
        #2 reset_n = 1'b0;
        refresh = 1'b0; grant = 1'b0;
        #1 check_val("async_rst_outs", 32'(outs()), 32'(V_IDLE));
        @(negedge clk);
        check_val("held_rst_outs", 32'(outs()), 32'(V_IDLE));
        reset_n = 1'b1;
        run_seq(1'b0, 0, 0, "after_rst");

        run_dflt();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
